// File: rtl/fifo_pkg.sv
// Shared types and elaboration helpers for the FIFO frame reader.
package fifo_pkg;

  typedef enum logic {IDLE, SEND} rd_state_t;

  // True when an index of aw bits can address every word of the frame.
  function automatic bit index_width_ok(input int unsigned words, input int unsigned aw);
    return 32'($clog2(words)) <= aw;
  endfunction

endpackage

// File: rtl/frame_shadow_reg.sv
// Load-enabled m x n register array holding the captured frame.
module frame_shadow_reg #(
  parameter int unsigned n = 32,
  parameter int unsigned m = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [n-1:0] d_i [0:m-1],
  output logic [n-1:0] q_o [0:m-1]
);

  logic [n-1:0] shadow_d [0:m-1];
  logic [n-1:0] shadow_q [0:m-1];

  always_comb begin
    shadow_d = shadow_q;
    if (load_i) shadow_d = d_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(m); i++) shadow_q[i] <= '0;
    end else begin
      shadow_q <= shadow_d;
    end
  end

  assign q_o = shadow_q;

endmodule

// File: rtl/fifo_frame_reader_n_m.sv
// Captures a parallel m-word frame and streams it out word by word on valid/ready.
// Optional FIFO_READER_LEN_EN adds a per-frame length input sampled at accept.
module fifo_frame_reader_n_m
  import fifo_pkg::*;
#(
  parameter int unsigned n       = 32,
  parameter int unsigned address = 4,
  parameter int unsigned m       = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [n-1:0]       frame_i [0:m-1],
  input  logic               frame_vld_i,
  output logic               frame_rdy_o,
  input  logic               flush_i,
`ifdef FIFO_READER_LEN_EN
  input  logic [address:0]   len_i,
`endif
  output logic [n-1:0]       data_o,
  output logic               vld_o,
  input  logic               rdy_i,
  output logic               last_o,
  output logic [address-1:0] idx_o,
  output logic               busy_o
);

  localparam int unsigned LW = address + 1;
  localparam logic [address-1:0] LAST_FULL = address'(m - 1);

  if (!index_width_ok(m, address)) begin : g_bad_width
    $error("fifo_frame_reader_n_m: m does not fit in address bits");
  end

  rd_state_t          state_d, state_q;
  logic [address-1:0] idx_d, idx_q;
  logic [address-1:0] last_idx_d, last_idx_q;
  logic               out_en_d, out_en_q;
  logic               load;
  logic               accept;
  logic [n-1:0]       shadow [0:m-1];

`ifdef FIFO_READER_LEN_EN
  logic [address:0] len_eff;
  assign len_eff = (len_i > LW'(m)) ? LW'(m) : len_i;
`endif

  frame_shadow_reg #(.n(n), .m(m)) u_shadow (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (load),
    .d_i    (frame_i),
    .q_o    (shadow)
  );

  // out_en_q keeps frame_rdy_o low until the first edge after reset release.
  assign accept = out_en_q & (state_q == IDLE) & frame_vld_i & ~flush_i;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    last_idx_d = last_idx_q;
    out_en_d   = 1'b1;
    load       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          load  = 1'b1;
          idx_d = '0;
`ifdef FIFO_READER_LEN_EN
          // A zero-length frame is consumed without leaving IDLE.
          if (len_eff != '0) begin
            last_idx_d = address'(len_eff - LW'(1));
            state_d    = SEND;
          end
`else
          last_idx_d = LAST_FULL;
          state_d    = SEND;
`endif
        end
      end
      SEND: begin
        if (flush_i) begin
          state_d = IDLE;
          idx_d   = '0;
        end else if (rdy_i) begin
          if (idx_q == last_idx_q) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + address'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      last_idx_q <= '0;
      out_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      last_idx_q <= last_idx_d;
      out_en_q   <= out_en_d;
    end
  end

  assign frame_rdy_o = out_en_q & (state_q == IDLE);
  assign vld_o       = (state_q == SEND);
  assign busy_o      = (state_q == SEND);
  assign idx_o       = idx_q;
  assign last_o      = (state_q == SEND) & (idx_q == last_idx_q);
  assign data_o      = (state_q == SEND) ? shadow[idx_q] : '0;

endmodule
